// File: rtl/prog_loader.sv
// prog_loader: UART (8N1) program loader. Receives a framed image
//   A5 | count_hi | count_lo | count x 4 bytes (big-endian) | xor checksum
// and writes each 32-bit word to instruction memory, holding the core halted
// until a frame with a good checksum completes.
// Optional build macro LOADER_TIMEOUT_EN adds an inter-byte timeout that
// aborts a stalled frame after TIMEOUT_BITS bit-times of silence.
//
// state    | meaning
// ---------+------------------------------------------------------------
// F_IDLE   | waiting for 0xA5 header, other bytes ignored
// F_CNT_HI | expecting high byte of word count
// F_CNT_LO | expecting low byte of word count, range-checked here
// F_DATA   | assembling 4-byte words, one write strobe per word
// F_CSUM   | expecting checksum byte
// F_DONE   | good frame, core released
// F_ERR    | bad frame, sticky error raised
module prog_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int MAX_WORDS    = 1024,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx,
   output logic        o_we,
   output logic [31:0] o_waddr,
   output logic [31:0] o_wdata,
   output logic        o_busy,
   output logic        o_run,
   output logic        o_err
);

   localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
   localparam logic [31:0] MAXW      = 32'(MAX_WORDS);

   if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_param
      $error("prog_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
   end

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {F_IDLE, F_CNT_HI, F_CNT_LO, F_DATA, F_CSUM, F_DONE, F_ERR} f_state_t;

   logic        rx_m_q, rx_s_q, rx_p_q;
   rx_state_t   rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        byte_valid, frame_err, start_det;

   f_state_t    f_st_q;
   logic [7:0]  cnt_hi_q, csum_q;
   logic [15:0] count_q;
   logic [23:0] asm_q;
   logic [1:0]  byte_cnt_q;
   logic [31:0] word_idx_q, waddr_q, wdata_q;
   logic        we_q, busy_q, run_q, err_q;
   logic        tmo_hit, fail;

   // Two-stage synchronizer plus previous-sample register for edge detect.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
         rx_p_q <= 1'b1;
      end else begin
         rx_m_q <= i_rx;
         rx_s_q <= rx_m_q;
         rx_p_q <= rx_s_q;
      end
   end

   // UART bit timing: half-bit start recheck, then one sample per bit period.
   always_comb begin
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      start_det  = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            if (rx_p_q && !rx_s_q) begin
               start_det = 1'b1;
               rx_st_d   = RX_START;
               rx_cnt_d  = HALF_LOAD;
            end
         end
         RX_START: begin
            if (rx_cnt_q == 16'd0) begin
               if (!rx_s_q) begin
                  rx_st_d  = RX_DATA;
                  rx_cnt_d = BIT_LOAD;
                  rx_bit_d = 3'd0;
               end else begin
                  rx_st_d = RX_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == 16'd0) begin
               rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
               rx_cnt_d = BIT_LOAD;
               if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
               else                  rx_bit_d = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == 16'd0) begin
               rx_st_d    = RX_IDLE;
               byte_valid = rx_s_q;
               frame_err  = !rx_s_q;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   // UART receiver state registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_st_q  <= RX_IDLE;
         rx_cnt_q <= 16'd0;
         rx_bit_q <= 3'd0;
         rx_sh_q  <= 8'd0;
      end else begin
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   logic [31:0] tmo_q;

   // Inter-byte silence timer, only armed while a frame is open.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                   tmo_q <= TMO_LOAD;
      else if (!busy_q || byte_valid || start_det) tmo_q <= TMO_LOAD;
      else if (tmo_q != 32'd0)                     tmo_q <= tmo_q - 32'd1;
   end

   assign tmo_hit = busy_q && (tmo_q == 32'd0);
`else
   assign tmo_hit = 1'b0;
`endif

   // Any condition that aborts an open frame.
   always_comb begin
      fail = tmo_hit || (frame_err && busy_q);
      if (byte_valid && f_st_q == F_CNT_LO && ({16'd0, cnt_hi_q, rx_sh_q} > MAXW)) fail = 1'b1;
      if (byte_valid && f_st_q == F_CSUM && (rx_sh_q != csum_q))                    fail = 1'b1;
   end

   // Frame FSM with registered memory-write and status outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         f_st_q     <= F_IDLE;
         cnt_hi_q   <= 8'd0;
         count_q    <= 16'd0;
         csum_q     <= 8'd0;
         asm_q      <= 24'd0;
         byte_cnt_q <= 2'd0;
         word_idx_q <= 32'd0;
         we_q       <= 1'b0;
         waddr_q    <= 32'd0;
         wdata_q    <= 32'd0;
         busy_q     <= 1'b0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         we_q <= 1'b0;
         if (fail) begin
            err_q  <= 1'b1;
            run_q  <= 1'b0;
            busy_q <= 1'b0;
            f_st_q <= F_ERR;
         end else begin
            case (f_st_q)
               F_IDLE: if (byte_valid && rx_sh_q == 8'hA5) begin
                  run_q      <= 1'b0;
                  err_q      <= 1'b0;
                  csum_q     <= 8'd0;
                  word_idx_q <= 32'd0;
                  byte_cnt_q <= 2'd0;
                  busy_q     <= 1'b1;
                  f_st_q     <= F_CNT_HI;
               end
               F_CNT_HI: if (byte_valid) begin
                  cnt_hi_q <= rx_sh_q;
                  csum_q   <= csum_q ^ rx_sh_q;
                  f_st_q   <= F_CNT_LO;
               end
               F_CNT_LO: if (byte_valid) begin
                  csum_q  <= csum_q ^ rx_sh_q;
                  count_q <= {cnt_hi_q, rx_sh_q};
                  f_st_q  <= ({cnt_hi_q, rx_sh_q} == 16'd0) ? F_CSUM : F_DATA;
               end
               F_DATA: if (byte_valid) begin
                  csum_q     <= csum_q ^ rx_sh_q;
                  asm_q      <= {asm_q[15:0], rx_sh_q};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     we_q       <= 1'b1;
                     wdata_q    <= {asm_q, rx_sh_q};
                     waddr_q    <= word_idx_q << 2;
                     word_idx_q <= word_idx_q + 32'd1;
                     if ((word_idx_q + 32'd1) == {16'd0, count_q}) f_st_q <= F_CSUM;
                  end
               end
               F_CSUM: if (byte_valid) begin
                  run_q  <= 1'b1;
                  busy_q <= 1'b0;
                  f_st_q <= F_DONE;
               end
               F_DONE:  f_st_q <= F_IDLE;
               F_ERR:   f_st_q <= F_IDLE;
               default: f_st_q <= F_IDLE;
            endcase
         end
      end
   end

   assign o_we    = we_q;
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;
   assign o_busy  = busy_q;
   assign o_run   = run_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of whole frames with hand-computed
// writes and final status, plus hand sequences for glitch, framing error,
// timeout and asynchronous reset behaviour.
module tb_prog_loader;

   localparam int CPB   = 8;
   localparam int MAXW  = 4;
   localparam int TBITS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        we;
   logic [31:0] waddr, wdata;
   logic        busy, run, err;

   int total = 0;
   int bad   = 0;

   int          wr_n = 0;
   logic [31:0] wa [64];
   logic [31:0] wd [64];

   typedef struct {
      int          nb;
      logic [95:0] bytes;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        run;
      logic        err;
   } vec_t;

   vec_t vt [6];

   always #5 clk = ~clk;

   prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .TIMEOUT_BITS(TBITS)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_rx    (rx),
      .o_we    (we),
      .o_waddr (waddr),
      .o_wdata (wdata),
      .o_busy  (busy),
      .o_run   (run),
      .o_err   (err)
   );

   // Capture every write strobe; a strobe longer than one cycle shows as extra writes.
   always @(negedge clk) begin
      if (we && wr_n < 64) begin
         wa[wr_n] <= waddr;
         wd[wr_n] <= wdata;
         wr_n     <= wr_n + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(posedge clk);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * CPB) @(posedge clk);
   endtask

   task automatic sample_point;
      @(negedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " we"},    {31'd0, we},   32'd0);
      check({tag, " waddr"}, waddr,         32'd0);
      check({tag, " wdata"}, wdata,         32'd0);
      check({tag, " busy"},  {31'd0, busy}, 32'd0);
      check({tag, " run"},   {31'd0, run},  32'd0);
      check({tag, " err"},   {31'd0, err},  32'd0);
   endtask

   initial begin
      int   base;
      vec_t cur;

      vt[0] = '{12, 96'hA5_00_02_12_34_56_78_9A_BC_DE_F0_02, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0};
      vt[1] = '{12, 96'hA5_00_02_12_34_56_78_9A_BC_DE_F0_03, 2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1};
      vt[2] = '{12, 96'hA5_00_02_12_34_56_78_9A_BC_DE_F0_02, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0};
      vt[3] = '{4,  {32'hA5_00_00_00, 64'd0},                0, 32'd0, 32'd0, 1'b1, 1'b0};
      vt[4] = '{3,  {24'hA5_00_05, 72'd0},                   0, 32'd0, 32'd0, 1'b0, 1'b1};
      vt[5] = '{10, {80'h11_22_A5_00_01_A5_00_00_01_A5, 16'd0}, 1, 32'hA5000001, 32'd0, 1'b1, 1'b0};

      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      sample_point();
      check_outputs_zero("reset");
      rst = 1'b0;
      idle_bits(2);

      for (int k = 0; k < 6; k++) begin
         cur  = vt[k];
         base = wr_n;
         for (int j = 0; j < cur.nb; j++) send_byte(cur.bytes[95 - 8*j -: 8], 1'b1);
         idle_bits(2);
         sample_point();
         check($sformatf("vec%0d nwrites", k), 32'(wr_n - base), 32'(cur.nw));
         if (cur.nw >= 1) begin
            check($sformatf("vec%0d addr0", k), wa[base], 32'h0);
            check($sformatf("vec%0d data0", k), wd[base], cur.w0);
         end
         if (cur.nw >= 2) begin
            check($sformatf("vec%0d addr1", k), wa[base+1], 32'h4);
            check($sformatf("vec%0d data1", k), wd[base+1], cur.w1);
         end
         check($sformatf("vec%0d run", k),  {31'd0, run},  {31'd0, cur.run});
         check($sformatf("vec%0d err", k),  {31'd0, err},  {31'd0, cur.err});
         check($sformatf("vec%0d busy", k), {31'd0, busy}, 32'd0);
      end

      // Framing error while idle: discarded, status untouched (run=1, err=0).
      send_byte(8'hA5, 1'b0);
      idle_bits(2);
      sample_point();
      check("idle ferr run",  {31'd0, run},  32'd1);
      check("idle ferr err",  {31'd0, err},  32'd0);
      check("idle ferr busy", {31'd0, busy}, 32'd0);

      // Short low glitch between data bytes must not become a byte.
      base = wr_n;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      sample_point();
      check("glitch busy mid", {31'd0, busy}, 32'd1);
      check("glitch run mid",  {31'd0, run},  32'd0);
      @(posedge clk);
      rx = 1'b0;
      repeat (2) @(posedge clk);
      rx = 1'b1;
      idle_bits(3);
      send_byte(8'h56, 1'b1);
      send_byte(8'h78, 1'b1);
      send_byte(8'h09, 1'b1);
      idle_bits(2);
      sample_point();
      check("glitch nwrites", 32'(wr_n - base), 32'd1);
      check("glitch data",    wd[base],         32'h12345678);
      check("glitch run",     {31'd0, run},     32'd1);
      check("glitch err",     {31'd0, err},     32'd0);

      // Framing error inside DATA aborts the frame.
      base = wr_n;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b0);
      idle_bits(1);
      sample_point();
      check("ferr err",     {31'd0, err},     32'd1);
      check("ferr busy",    {31'd0, busy},    32'd0);
      check("ferr run",     {31'd0, run},     32'd0);
      check("ferr nwrites", 32'(wr_n - base), 32'd0);

      // Next header clears the sticky error; then stall mid-frame.
      base = wr_n;
      send_byte(8'hA5, 1'b1);
      sample_point();
      check("hdr clears err", {31'd0, err},  32'd0);
      check("hdr busy",       {31'd0, busy}, 32'd1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      idle_bits(9);
      sample_point();
`ifdef LOADER_TIMEOUT_EN
      check("timeout err",  {31'd0, err},  32'd1);
      check("timeout busy", {31'd0, busy}, 32'd0);
      check("timeout run",  {31'd0, run},  32'd0);
`else
      check("stall err",  {31'd0, err},  32'd0);
      check("stall busy", {31'd0, busy}, 32'd1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h78, 1'b1);
      send_byte(8'h09, 1'b1);
      idle_bits(2);
      sample_point();
      check("stall nwrites", 32'(wr_n - base), 32'd1);
      check("stall data",    wd[base],         32'h12345678);
      check("stall run",     {31'd0, run},     32'd1);
      check("stall err end", {31'd0, err},     32'd0);
`endif

      // Asynchronous reset mid-frame: outputs clear before the next clock edge.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      sample_point();
      check("pre-rst busy",  {31'd0, busy}, 32'd1);
      check("pre-rst wdata", wdata,         32'h12345678);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_outputs_zero("async rst");
      repeat (2) @(posedge clk);
      rst = 1'b0;
      idle_bits(1);
      sample_point();
      check("post-rst busy", {31'd0, busy}, 32'd0);
      check("post-rst run",  {31'd0, run},  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
